// File: rtl/bias_collector.sv
// bias_collector
//   Runs a batch of NUM_RUNS measurements on an upstream DES counting block
//   and reports the sum and the maximum of the per-run absolute bias
//   |count - SAMPLES_PER_RUN/2|.
//
//   Each run: CLEAR (block_clear pulse) -> LAUNCH (block_start pulse) ->
//   WAIT (until block_valid or timeout) -> ACCUM. After the last run, or
//   after a timeout, the FSM sits in DONE presenting the result.
//
//   Handshake: the result is offered with result_valid=1 in DONE and held
//   stable; it is consumed on the rising edge where result_valid and
//   result_ready are both 1. result_valid falls in the following cycle.
//   result_ready is ignored whenever result_valid=0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse, begins a batch in IDLE
//   block_counter   count of ones from the counting block
//   block_valid     block_counter is final for the current run
//   block_clear     registered pulse clearing the counting block
//   block_start     registered pulse starting the counting block
//   sum_abs_bias    sum of per-run absolute bias (cannot overflow)
//   max_abs_bias    largest per-run absolute bias
//   runs_done       runs completed in the current or last batch
//   timeout_err     batch aborted because a run timed out
//   busy            high in every state except IDLE and DONE
//   result_valid    result outputs are valid and stable
//   result_ready    downstream accepts the result
module bias_collector #(
  parameter int NUM_RUNS        = 16,
  parameter int SAMPLES_PER_RUN = 1000,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int SUM_W          = 10 + $clog2(NUM_RUNS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       block_counter,
  input  logic             block_valid,
  output logic             block_clear,
  output logic             block_start,
  output logic [SUM_W-1:0] sum_abs_bias,
  output logic [9:0]       max_abs_bias,
  output logic [10:0]      runs_done,
  output logic             timeout_err,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0]    T_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [10:0] HALF  = 11'(SAMPLES_PER_RUN / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LAUNCH, S_WAIT, S_ACCUM, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TCW-1:0]   tcnt_q;
  logic [9:0]       sample_q;
  logic [10:0]      runs_inc;
  logic signed [10:0] diff;
  logic [10:0]      mag;
  logic [9:0]       abs_bias;

  assign runs_inc = runs_done + 11'd1;

  // Signed distance from the ideal half count; the 11-bit magnitude is
  // clamped to 10 bits so it always fits max_abs_bias.
  always_comb begin
    diff     = $signed({1'b0, sample_q}) - HALF;
    mag      = diff[10] ? 11'(-diff) : 11'(diff);
    abs_bias = mag[10] ? 10'h3FF : mag[9:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. In WAIT a valid sample takes priority over the
  // timeout check, so a sample on the last allowed cycle is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (block_valid)           state_d = S_ACCUM;
        else if (tcnt_q == T_LAST) state_d = S_DONE;
      end
      S_ACCUM:  state_d = (runs_inc < 11'(NUM_RUNS)) ? S_CLEAR : S_DONE;
      S_DONE:   if (result_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered strobes. The strobes are decoded from the
  // next state so each is high exactly while the FSM is in its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_clear  <= 1'b0;
      block_start  <= 1'b0;
      sum_abs_bias <= '0;
      max_abs_bias <= '0;
      runs_done    <= '0;
      timeout_err  <= 1'b0;
      tcnt_q       <= '0;
      sample_q     <= '0;
    end else begin
      block_clear <= (state_d == S_CLEAR);
      block_start <= (state_d == S_LAUNCH);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sum_abs_bias <= '0;
            max_abs_bias <= '0;
            runs_done    <= '0;
            timeout_err  <= 1'b0;
          end
        end
        S_LAUNCH: tcnt_q <= '0;
        S_WAIT: begin
          if (block_valid)           sample_q    <= block_counter;
          else if (tcnt_q == T_LAST) timeout_err <= 1'b1;
          else                       tcnt_q      <= tcnt_q + TCW'(1);
        end
        S_ACCUM: begin
          sum_abs_bias <= sum_abs_bias + SUM_W'(abs_bias);
          if (abs_bias > max_abs_bias) max_abs_bias <= abs_bias;
          runs_done <= runs_inc;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign result_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_bias_collector.sv
module tb_bias_collector;

  localparam int NR  = 4;
  localparam int SPR = 1000;
  localparam int TO  = 16;
  localparam int SW  = 10 + $clog2(NR);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, block_valid, result_ready;
  logic [9:0]    block_counter;
  logic          block_clear, block_start, timeout_err, busy, result_valid;
  logic [SW-1:0] sum_abs_bias;
  logic [9:0]    max_abs_bias;
  logic [10:0]   runs_done;

  bias_collector #(.NUM_RUNS(NR), .SAMPLES_PER_RUN(SPR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .block_counter(block_counter), .block_valid(block_valid),
    .block_clear(block_clear), .block_start(block_start),
    .sum_abs_bias(sum_abs_bias), .max_abs_bias(max_abs_bias),
    .runs_done(runs_done), .timeout_err(timeout_err), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  int b_cnt[NR];
  int b_dly[NR];
  int exp_sum, exp_max, exp_runs, exp_to;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) check("clr_start_excl", 32'(block_clear & block_start), 0);

  // Reference: per-run bias straight from the definition.
  function automatic int abs_bias(input int c);
    int d;
    d = c - SPR / 2;
    if (d < 0) d = -d;
    if (d > 1023) d = 1023;
    return d;
  endfunction

  // A run whose response would come later than TO WAIT cycles times out
  // and ends the batch.
  task automatic model_batch();
    int a;
    exp_sum = 0; exp_max = 0; exp_runs = 0; exp_to = 0;
    for (int r = 0; r < NR; r++) begin
      if (b_dly[r] >= TO) begin
        exp_to = 1;
        break;
      end
      a = abs_bias(b_cnt[r]);
      exp_sum += a;
      if (a > exp_max) exp_max = a;
      exp_runs++;
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_sum"},   32'(sum_abs_bias), 0);
    check({pfx, "_max"},   32'(max_abs_bias), 0);
    check({pfx, "_runs"},  32'(runs_done), 0);
    check({pfx, "_to"},    32'(timeout_err), 0);
  endtask

  // ---------------- driver ----------------
  // b_dly[r] = extra WAIT cycles before block_valid (0 = first WAIT cycle).
  task automatic run_batch(input int hold, input int rst_run);
    model_batch();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;           // now in CLEAR of run 0
    check_zero("start_zero");
    for (int r = 0; r < NR; r++) begin
      check("clear_pulse", 32'(block_clear), 1);
      check("clear_busy", 32'(busy), 1);
      result_ready = 1'($urandom_range(0, 1));  // must be ignored outside DONE
      @(negedge clk);                           // LAUNCH
      check("launch_pulse", 32'(block_start), 1);
      block_valid   = 1'($urandom_range(0, 1)); // must be ignored in LAUNCH
      block_counter = 10'($urandom_range(0, 1023));
      start         = 1'($urandom_range(0, 1)); // must be ignored while busy
      @(negedge clk);                           // WAIT cycle 1
      block_valid = 1'b0; start = 1'b0; result_ready = 1'b0;
      if (r == rst_run) begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        check("rst_clear", 32'(block_clear), 0);
        check("rst_start", 32'(block_start), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_rv",    32'(result_valid), 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_resume_busy",  32'(busy), 0);
        check("no_resume_clear", 32'(block_clear), 0);
        check("no_resume_rv",    32'(result_valid), 0);
        return;
      end
      if (b_dly[r] >= TO) begin
        repeat (TO - 1) @(negedge clk);         // last WAIT cycle
        check("to_last_rv",   32'(result_valid), 0);
        check("to_last_busy", 32'(busy), 1);
        @(negedge clk);
        check("to_flag", 32'(timeout_err), 1);
        check("to_rv",   32'(result_valid), 1);
        if (b_dly[r] == TO) begin               // late sample lands in DONE
          block_valid = 1'b1; block_counter = 10'(b_cnt[r]);
          @(negedge clk); block_valid = 1'b0;
        end
        break;
      end
      repeat (b_dly[r]) @(negedge clk);
      block_valid = 1'b1; block_counter = 10'(b_cnt[r]);
      @(negedge clk);                           // ACCUM
      block_valid = 1'b0;
      check("accum_busy", 32'(busy), 1);
      check("accum_rv",   32'(result_valid), 0);
      @(negedge clk);                           // next CLEAR or DONE
    end
    check("res_rv",   32'(result_valid), 1);
    check("res_busy", 32'(busy), 0);
    check("res_sum",  32'(sum_abs_bias), exp_sum);
    check("res_max",  32'(max_abs_bias), exp_max);
    check("res_runs", 32'(runs_done), exp_runs);
    check("res_to",   32'(timeout_err), exp_to);
    for (int i = 0; i < hold; i++) begin
      start = (i == 1);
      @(negedge clk);
      check("hold_rv",   32'(result_valid), 1);
      check("hold_sum",  32'(sum_abs_bias), exp_sum);
      check("hold_max",  32'(max_abs_bias), exp_max);
      check("hold_runs", 32'(runs_done), exp_runs);
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
    check("hs_rv_drop", 32'(result_valid), 0);
    check("idle_busy",  32'(busy), 0);
    check("idle_sum",   32'(sum_abs_bias), exp_sum);
    check("idle_max",   32'(max_abs_bias), exp_max);
    check("idle_runs",  32'(runs_done), exp_runs);
    repeat (2) @(negedge clk);
    check("idle_stays", 32'(busy), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; block_valid = 1'b0;
    block_counter = '0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    check("reset_clear", 32'(block_clear), 0);
    check("reset_start", 32'(block_start), 0);
    check("reset_busy",  32'(busy), 0);
    check("reset_rv",    32'(result_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // nominal: sum 33, max 20
    b_cnt = '{500, 510, 480, 503}; b_dly = '{0, 2, 5, 1};
    run_batch(3, -1);
    // extremes: 500, 523, 0, 499
    b_cnt = '{0, 1023, 500, 1}; b_dly = '{1, 0, 3, 0};
    run_batch(1, -1);
    // timeout in run 2, with 50 cycles of backpressure
    b_cnt = '{520, 0, 0, 0}; b_dly = '{0, TO + 5, 0, 0};
    run_batch(50, -1);
    // sample on the exact timeout cycle wins
    b_cnt = '{777, 250, 600, 400}; b_dly = '{TO - 1, 0, TO - 1, 2};
    run_batch(2, -1);
    // sample one cycle too late: timeout, late sample ignored in DONE
    b_cnt = '{505, 495, 999, 0}; b_dly = '{3, TO, 0, 0};
    run_batch(0, -1);
    // reset during WAIT of run 3, then a full batch
    b_cnt = '{900, 100, 300, 700}; b_dly = '{0, 1, 4, 0};
    run_batch(0, 2);
    b_cnt = '{612, 388, 499, 501}; b_dly = '{2, 0, 1, 3};
    run_batch(1, -1);

    for (int k = 0; k < 14; k++) begin
      for (int r = 0; r < NR; r++) begin
        b_cnt[r] = int'($urandom_range(0, 1023));
        b_dly[r] = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1))
                                               : int'($urandom_range(0, 6));
      end
      run_batch(int'($urandom_range(0, 4)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
